// File: rtl/hack_boot_pkg.sv
// Shared types and constants for the hack_cpu serial program loader.
package hack_boot_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_SUM,
    S_RUN,
    S_ERR
  } boot_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SUM     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_LEN     = 2'b11;

  localparam logic [7:0] FRAME_SUM_OK = 8'h00;

  // States that consume frame bytes.
  function automatic logic is_receive(input boot_state_t s);
    return s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_SUM};
  endfunction

  // Inside a frame the sender must not go silent; LEN_HI waits indefinitely.
  function automatic logic timeout_armed(input boot_state_t s);
    return s inside {S_LEN_LO, S_DATA_HI, S_DATA_LO, S_SUM};
  endfunction

endpackage

// File: rtl/hack_boot_loader.sv
// Serial program loader: parses LEN/words/SUM frames from the UART, writes the
// instruction ROM, and holds hack_cpu in reset until a frame verifies.
module hack_boot_loader
  import hack_boot_pkg::*;
#(
  parameter int ROM_DEPTH   = 32768,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int ADDR_W     = $clog2(ROM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              load_req,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              loading,
  output logic              running,
  output logic [1:0]        err_code
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [16:0]       MAX_LEN   = 17'(ROM_DEPTH);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);

  boot_state_t       state;
  logic [7:0]        len_hi;
  logic [7:0]        data_hi;
  logic [7:0]        sum;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic [7:0]  sum_next;
  logic [15:0] len_rx;
  logic        len_too_big;

  assign sum_next    = sum + rx_data;
  assign len_rx      = {len_hi, rx_data};
  assign len_too_big = {1'b0, len_rx} > MAX_LEN;

  // NOTE: every register here is state, so it uses <= only; a blocking
  // assignment would let later statements in this block see the new value
  // within the same edge and silently change the frame timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LEN_HI;
      len_hi    <= '0;
      data_hi   <= '0;
      sum       <= '0;
      len       <= '0;
      word_cnt  <= '0;
      idle_cnt  <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      loading   <= 1'b1;
      running   <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      rom_we    <= 1'b0;
      cpu_reset <= 1'b1;

      // load_req outranks everything, including a byte arriving this cycle.
      if (load_req) begin
        state    <= S_LEN_HI;
        sum      <= '0;
        word_cnt <= '0;
        idle_cnt <= '0;
        err_code <= ERR_NONE;
        loading  <= 1'b1;
        running  <= 1'b0;
      end else if (state == S_RUN) begin
        // Released one cycle after entering S_RUN so the CPU restarts at PC 0.
        cpu_reset <= 1'b0;
      end else if (is_receive(state)) begin
        if (rx_valid) begin
          idle_cnt <= '0;
          sum      <= sum_next;
          case (state)
            S_LEN_HI: begin
              len_hi <= rx_data;
              state  <= S_LEN_LO;
            end
            S_LEN_LO: begin
              len <= len_rx;
              if (len_too_big) begin
                state    <= S_ERR;
                err_code <= ERR_LEN;
                loading  <= 1'b0;
              end else if (len_rx == 16'd0) begin
                state <= S_SUM;
              end else begin
                state <= S_DATA_HI;
              end
            end
            S_DATA_HI: begin
              data_hi <= rx_data;
              state   <= S_DATA_LO;
            end
            S_DATA_LO: begin
              rom_we    <= 1'b1;
              rom_addr  <= word_cnt[ADDR_W-1:0];
              rom_wdata <= {data_hi, rx_data};
              word_cnt  <= word_cnt + 16'd1;
              state     <= (word_cnt == len - 16'd1) ? S_SUM : S_DATA_HI;
            end
            S_SUM: begin
              loading <= 1'b0;
              if (sum_next == FRAME_SUM_OK) begin
                state   <= S_RUN;
                running <= 1'b1;
              end else begin
                state    <= S_ERR;
                err_code <= ERR_SUM;
              end
            end
            default: state <= S_LEN_HI;
          endcase
        end else if (timeout_armed(state)) begin
          // Saturate at the limit so a stalled sender can never wrap back to "fresh".
          if (idle_cnt >= IDLE_LAST) begin
            idle_cnt <= IDLE_MAX;
            state    <= S_ERR;
            err_code <= ERR_TIMEOUT;
            loading  <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Self-checking bench for hack_boot_loader: frame table plus hand-written
// timeout, abort and reset sequences, with a ROM-write scoreboard.
module tb_hack_boot_loader;

  localparam int ROM_DEPTH   = 32768;
  localparam int TIMEOUT_CYC = 100;
  localparam int ADDR_W      = 15;
  localparam int GAP         = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              load_req;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              cpu_reset;
  logic              loading;
  logic              running;
  logic [1:0]        err_code;

  always #5 clk = ~clk;

  hack_boot_loader #(
    .ROM_DEPTH  (ROM_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .load_req (load_req),
    .rom_we   (rom_we),
    .rom_addr (rom_addr),
    .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset),
    .loading  (loading),
    .running  (running),
    .err_code (err_code)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  typedef struct {
    string            name;
    int               n;
    logic [0:11][7:0] b;
    logic             run;
    logic [1:0]       err;
  } frame_t;

  int     compared   = 0;
  int     mismatched = 0;
  int     writes_seen = 0;
  wr_t    exp_q[$];
  frame_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every rom_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rom_we: got write addr=%0h data=%0h, expected no write (t=%0t)",
                 rom_addr, rom_wdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("rom_addr", 32'(rom_addr), 32'(e.addr));
        check("rom_wdata", 32'(rom_wdata), 32'(e.data));
      end
    end
  end

  task automatic pulse_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_wr);
    repeat (GAP) @(posedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    if (exp_wr) check("rom_we_latency", 32'(rom_we), 32'd1);
  endtask

  // Sends bytes [0, upto) of a frame, pushing the writes the frame format implies.
  task automatic send_bytes(input frame_t f, input int upto, output int n_wr);
    logic [15:0] len;
    len  = 16'd0;
    n_wr = 0;
    for (int i = 0; i < upto; i++) begin
      logic exp_wr;
      exp_wr = 1'b0;
      if (i == 1) len = {f.b[0], f.b[1]};
      if (i >= 3 && (i % 2) == 1 && 32'(len) <= ROM_DEPTH && (i - 3) / 2 < 32'(len)) begin
        exp_wr = 1'b1;
        n_wr++;
        exp_q.push_back('{addr: ADDR_W'((i - 3) / 2), data: {f.b[i-1], f.b[i]}});
      end
      send_byte(f.b[i], exp_wr);
    end
  endtask

  task automatic run_frame(input frame_t f);
    int n_wr;
    int seen0;
    seen0 = writes_seen;
    send_bytes(f, f.n, n_wr);
    if (f.run) begin
      check({f.name, "_running"}, 32'(running), 32'd1);
      check({f.name, "_cpu_reset_entry"}, 32'(cpu_reset), 32'd1);
      @(posedge clk);
      #1 check({f.name, "_cpu_reset_release"}, 32'(cpu_reset), 32'd0);
    end else begin
      check({f.name, "_cpu_reset_held"}, 32'(cpu_reset), 32'd1);
      check({f.name, "_running"}, 32'(running), 32'd0);
    end
    check({f.name, "_err_code"}, 32'(err_code), 32'(f.err));
    check({f.name, "_loading"}, 32'(loading), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({f.name, "_write_count"}, 32'(writes_seen - seen0), 32'(n_wr));
    check({f.name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle_loading(input string name);
    check({name, "_loading"}, 32'(loading), 32'd1);
    check({name, "_err_clear"}, 32'(err_code), 32'd0);
    check({name, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({name, "_running"}, 32'(running), 32'd0);
  endtask

  initial begin
    int n_wr;

    tbl[0] = '{"f3words", 9, 96'h00030011_EC10E308_05000000, 1'b1, 2'b00};
    tbl[1] = '{"badsum",  9, 96'h00030011_EC10E308_06000000, 1'b0, 2'b01};
    tbl[2] = '{"len8001", 2, 96'h80010000_00000000_00000000, 1'b0, 2'b11};
    tbl[3] = '{"len0",    3, 96'h00000000_00000000_00000000, 1'b1, 2'b00};
    tbl[4] = '{"f1word",  5, 96'h00011234_B9000000_00000000, 1'b1, 2'b00};
    tbl[5] = '{"f2words", 7, 96'h0002ABCD_01236200_00000000, 1'b1, 2'b00};
    tbl[6] = '{"lenffff", 2, 96'hFFFF0000_00000000_00000000, 1'b0, 2'b11};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    load_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rom_we", 32'(rom_we), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_rom_wdata", 32'(rom_wdata), 32'd0);
    check_idle_loading("reset");
    reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      pulse_load_req();
      check_idle_loading({tbl[k].name, "_start"});
      run_frame(tbl[k]);
      if (tbl[k].run) begin
        // Bytes are ignored while running.
        send_byte(8'h5A, 1'b0);
        check({tbl[k].name, "_run_ignores_rx"}, 32'(running), 32'd1);
      end else begin
        send_byte(8'h00, 1'b0);
        check({tbl[k].name, "_err_held"}, 32'(err_code), 32'(tbl[k].err));
      end
    end

    // Timeout: silence after one word fires at exactly TIMEOUT_CYC idle cycles.
    pulse_load_req();
    send_bytes(tbl[0], 4, n_wr);
    repeat (TIMEOUT_CYC - 1) @(posedge clk);
    #1;
    check("timeout_not_early", 32'(err_code), 32'd0);
    check("timeout_not_early_loading", 32'(loading), 32'd1);
    @(posedge clk);
    #1;
    check("timeout_err_code", 32'(err_code), 32'd2);
    check("timeout_cpu_reset", 32'(cpu_reset), 32'd1);
    check("timeout_loading", 32'(loading), 32'd0);
    check("timeout_writes", 32'(n_wr), 32'd1);
    check("timeout_pending", 32'(exp_q.size()), 32'd0);

    // Mid-frame abort: load_req restarts word addressing at 0.
    pulse_load_req();
    send_bytes(tbl[0], 5, n_wr);
    pulse_load_req();
    check_idle_loading("abort");
    run_frame(tbl[0]);

    // In S_RUN, load_req coincident with a byte: the byte is dropped.
    @(negedge clk);
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h7F;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    check_idle_loading("coincident");
    run_frame(tbl[0]);

    // Reset mid-load behaves like power-on.
    pulse_load_req();
    send_bytes(tbl[5], 4, n_wr);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midreset_rom_addr", 32'(rom_addr), 32'd0);
    check("midreset_rom_wdata", 32'(rom_wdata), 32'd0);
    check_idle_loading("midreset");
    reset = 1'b0;
    run_frame(tbl[0]);

    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
